// File: rtl/fsm.sv
// rtl/fsm.sv - synchronised, debounced rising-edge detector emitting a one-cycle pulse
module fsm #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bi,
    output logic bo
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    // Comparing against DEBOUNCE-1 is the same test as cnt+1 == DEBOUNCE without the carry.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        LOW      = 3'd0,
        CHK_HIGH = 3'd1,
        PULSE    = 3'd2,
        HIGH     = 3'd3,
        CHK_LOW  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync[0] <= bi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    // bo is set on the same edge that enters PULSE, so it tracks state==PULSE from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOW;
            cnt   <= '0;
            bo    <= 1'b0;
        end else begin
            bo <= 1'b0;
            case (state)
                LOW: begin
                    if (s) begin
                        if (DEBOUNCE == 1) begin
                            state <= PULSE;
                            bo    <= 1'b1;
                        end else begin
                            state <= CHK_HIGH;
                            cnt   <= CW'(1);
                        end
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= PULSE;
                        cnt   <= '0;
                        bo    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PULSE: begin
                    state <= HIGH;
                end
                HIGH: begin
                    if (!s) begin
                        if (DEBOUNCE == 1) begin
                            state <= LOW;
                        end else begin
                            state <= CHK_LOW;
                            cnt   <= CW'(1);
                        end
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm.sv
// tb/tb_fsm.sv - directed-vector bench for the debounced edge detector
module tb_fsm;

    logic clk;
    logic rst;
    logic bi;
    logic bo;

    int n_cmp = 0;
    int n_err = 0;

    fsm #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bi (bi),
        .bo (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: bo=%0b expected %0b", tag, got, exp);
        end
    endtask

    // Bit n-1 is the first cycle; bi is driven mid-cycle, bo is checked 2 time units after the edge.
    task automatic run_vec(input string tag, input int n, input logic [63:0] bi_v, input logic [63:0] bo_v);
        for (int i = 0; i < n; i++) begin
            bi = bi_v[n-1-i];
            @(posedge clk);
            #2;
            check_eq($sformatf("%s[%0d]", tag, i + 1), bo, bo_v[n-1-i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        bi  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check_eq($sformatf("in_reset[%0d]", i + 1), bo, 1'b0);
        end
        rst = 1'b1;
        run_vec("reset_release", 11, {6'b111111, 5'b00000}, {4'b0001, 7'b0});

        run_vec("clean_press", 14, 14'b01100011100000, 14'b00001000010000);

        run_vec("glitch", 7, 7'b0100000, 7'b0000000);

        run_vec("held_high", 25, {20'hFFFFF, 5'b00000}, {4'b0001, 21'b0});

        run_vec("low_dip", 20, {6'b111111, 1'b0, 4'b1111, 2'b00, 2'b11, 5'b00000},
                {4'b0001, 12'b0, 1'b1, 3'b000});

        run_vec("pre_async", 4, 4'b1111, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_drop", bo, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check_eq($sformatf("async_hold[%0d]", i + 1), bo, 1'b0);
        end
        rst = 1'b1;
        run_vec("post_async", 11, {6'b111111, 5'b00000}, {4'b0001, 7'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm.md
Name: fsm

Overview:
- Synchronised, debounced rising-edge detector for a single asynchronous input bit.
- bi passes through a flip-flop synchroniser chain, then into a Moore FSM.
- The FSM emits a one-clock pulse on bo once per debounced low-to-high transition of bi.
- Sits at the boundary between an asynchronous source (button, external line) and synchronous control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops on bi; legal range >=1.
- DEBOUNCE, 2, consecutive synchronised samples of the new level required to accept a transition; legal range >=1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- bi   input  1  raw asynchronous input bit.
- bo   output 1  registered one-cycle pulse per accepted rising transition of bi.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous, immediate):
  - All synchroniser flops = 0.
  - FSM state = LOW, debounce counter = 0, bo = 0.
  - Leaving reset is synchronous to clk; no pulse is generated on reset release.
- Synchroniser: bi feeds a chain of SYNC_STAGES flops; s = last flop output. The FSM uses only s.
- Debounce counter: width clog2(DEBOUNCE+1).
- States and transitions (evaluated each rising clk edge):
  - LOW: bo=0.
    - s=1 and DEBOUNCE=1 -> PULSE.
    - s=1 and DEBOUNCE>1 -> CHK_HIGH, cnt=1.
    - else stay in LOW.
  - CHK_HIGH: bo=0.
    - s=0 -> LOW, cnt=0.
    - s=1: cnt+1 = DEBOUNCE -> PULSE; else cnt=cnt+1.
  - PULSE: bo=1 for exactly this one cycle. Unconditionally -> HIGH.
  - HIGH: bo=0.
    - s=0 and DEBOUNCE=1 -> LOW.
    - s=0 and DEBOUNCE>1 -> CHK_LOW, cnt=1.
    - else stay in HIGH.
  - CHK_LOW: bo=0.
    - s=1 -> HIGH, cnt=0.
    - s=0: cnt+1 = DEBOUNCE -> LOW, cnt=0; else cnt=cnt+1.
- State encoding: binary, 3 bits. Unused encodings -> LOW on next edge with bo=0.
- bo is decoded as a registered output, i.e. the flop value reflecting state==PULSE. bo is glitch-free.
- Latency: number edges from edge 1, the first rising edge that samples bi=1. bi stays high. bo is 1 for the cycle following edge SYNC_STAGES+DEBOUNCE. With defaults, bo is high between edge 4 and edge 5.
- Glitch rejection: a high level on bi shorter than DEBOUNCE sampled cycles produces no pulse.
- Low-level rejection: a low level shorter than DEBOUNCE sampled cycles while HIGH does not re-arm the detector.
- Held input: bi held high indefinitely gives exactly one pulse. A new pulse requires at least DEBOUNCE consecutive low samples, then at least DEBOUNCE high samples.
- Reset mid-operation, including during PULSE: bo drops to 0 immediately and the FSM returns to LOW. A level still high after reset must again satisfy the full sync+debounce latency to pulse.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE=2; bi changes mid-cycle after the clk rising edge):
- Reset: rst=0 with bi=1 for 3 cycles -> bo=0 throughout. Release rst -> first bo=1 exactly 4 edges after release, for one cycle.
- Clean press: bi sequence per cycle 0,1,1,0,0,0,1,1,1 after reset -> bo pulses once for the first 1,1 burst and once for the final 1,1,1 burst. Each pulse is 1 cycle wide and occurs 4 edges after the burst's first high sample.
- Glitch: bi=1 for a single cycle, surrounded by 0s -> bo never asserts.
- Held high: bi=1 for 20 cycles -> exactly one bo pulse.
- Short low dip: while HIGH, bi=0 for 1 cycle then 1 again -> no second pulse. With bi=0 for 2+ cycles then 1 for 2+ cycles -> second pulse.
- Async reset during PULSE: assert rst=0 mid-cycle while bo=1 -> bo=0 before the next clk edge. No pulse after release until a fresh debounced rise.
